// File: rtl/ins_prefetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect input and
// the instruction-queue head presented to the consumer.
interface ins_prefetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_ready;

   modport master (
      output mem_req, mem_addr, ins_valid, ins_out, ins_pc,
      input  mem_ack, mem_rdata, redirect, redirect_pc, ins_ready
   );

   modport slave (
      input  mem_req, mem_addr, ins_valid, ins_out, ins_pc,
      output mem_ack, mem_rdata, redirect, redirect_pc, ins_ready
   );
endinterface

// File: rtl/ins_prefetch.sv
// Instruction prefetcher: single outstanding fetch feeding a DEPTH-entry queue.
// Optional PREFETCH_STATS_EN adds a stall_cnt output counting starved consumer cycles.
module ins_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          rst,
   ins_prefetch_if.master bus
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc, fetch_pc_next;
   logic [31:0]   target, target_next;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   q_ins [DEPTH];
   logic [31:0]   q_pc  [DEPTH];
   logic          req, vld, push, pop, flush_q;
   logic [31:0]   redir_tgt;

   assign redir_tgt = bus.redirect_pc & ~32'd3;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      target_next   = target;
      push          = 1'b0;
      flush_q       = 1'b0;
      req           = 1'b0;
      vld           = 1'b0;
      if (!rst) begin
         vld = (state == RUN) && (count != '0);
         // FLUSH keeps the stale request asserted until memory acknowledges it.
         req = (state == RUN) ? (count < FULL) : 1'b1;
      end
      pop = vld && bus.ins_ready && !bus.redirect;
      case (state)
         RUN: begin
            if (bus.redirect) begin
               flush_q     = 1'b1;
               target_next = redir_tgt;
               if (req && !bus.mem_ack) state_next    = FLUSH;
               else                     fetch_pc_next = redir_tgt;
            end else if (req && bus.mem_ack) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + 32'd4;
            end
         end
         FLUSH: begin
            if (bus.redirect) target_next = redir_tgt;
            if (bus.mem_ack) begin
               fetch_pc_next = bus.redirect ? redir_tgt : target;
               state_next    = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         target   <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_ins[i] <= '0;
            q_pc[i]  <= '0;
         end
      end else begin
         fetch_pc <= fetch_pc_next;
         target   <= target_next;
         if (flush_q) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
         end else begin
            if (push) begin
               q_ins[wr_ptr] <= bus.mem_rdata;
               q_pc[wr_ptr]  <= fetch_pc;
               wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
      end
   end

`ifdef PREFETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                         stall_cnt <= '0;
      else if (bus.ins_ready && !vld)  stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   assign bus.mem_req   = req;
   assign bus.mem_addr  = fetch_pc;
   assign bus.ins_valid = vld;
   assign bus.ins_out   = q_ins[rd_ptr];
   assign bus.ins_pc    = q_pc[rd_ptr];

endmodule
